// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared data port (port B) of the on-chip RAM.
// M0 is the core load/store unit, M1 the debug/program loader. One transaction
// is in flight at a time. A timeout counter guarantees every accepted request
// is acknowledged, either with memory data or with an error flag.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 15,  // legal range 2..255
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,

  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [31:0]           i_m0_wr_data,
  input  logic [1:0]            i_m0_size,
  input  logic                  i_m0_we,
  input  logic                  i_m0_req,
  output logic [31:0]           o_m0_rd_data,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,

  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [31:0]           i_m1_wr_data,
  input  logic [1:0]            i_m1_size,
  input  logic                  i_m1_we,
  input  logic                  i_m1_req,
  output logic [31:0]           o_m1_rd_data,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,

  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wr_data,
  output logic [1:0]            o_mem_size,
  output logic                  o_mem_we,
  output logic                  o_mem_req,
  input  logic [31:0]           i_mem_rd_data,
  input  logic                  i_mem_ack
);

  localparam logic [7:0] TLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait0 = 2'd1,
    StWait1 = 2'd2
  } state_e;

  state_e      state_q;
  logic        lg_q;     // last granted requester: 0 = M0, 1 = M1
  logic [7:0]  tcnt_q;

  logic        any_req;
  logic        win;      // requester selected in IDLE: 0 = M0, 1 = M1
  logic        timeout;
  logic        done;
  logic        grant;
  logic [31:0] rsp_data;

  // Winner selection: a lone request wins, a tie goes by priority policy.
  always_comb begin
    any_req = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) begin
      win = ROUND_ROBIN ? ~lg_q : 1'b0;
    end else begin
      win = i_m1_req;
    end
  end

  // An ack landing in the timeout cycle still completes normally.
  assign timeout = (tcnt_q == TLast);
  assign done    = i_mem_ack | timeout;

  // State, last-grant pointer and timeout counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      lg_q    <= 1'b1;
      tcnt_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= win ? StWait1 : StWait0;
            lg_q    <= win;
            tcnt_q  <= '0;
          end
        end
        StWait0, StWait1: begin
          if (done) begin
            state_q <= StIdle;
          end else begin
            tcnt_q <= tcnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Memory-side forwarding and requester responses; strobes are held low during reset.
  always_comb begin
    grant         = ~i_rst & (state_q == StIdle) & any_req;
    o_mem_req     = grant;
    o_mem_addr    = win ? i_m1_addr : i_m0_addr;
    o_mem_wr_data = win ? i_m1_wr_data : i_m0_wr_data;
    o_mem_size    = win ? i_m1_size : i_m0_size;
    o_mem_we      = grant & (win ? i_m1_we : i_m0_we);

    rsp_data      = i_mem_ack ? i_mem_rd_data : ERR_DATA;
    o_m0_rd_data  = rsp_data;
    o_m1_rd_data  = rsp_data;
    o_m0_ack      = ~i_rst & (state_q == StWait0) & done;
    o_m1_ack      = ~i_rst & (state_q == StWait1) & done;
    o_m0_err      = o_m0_ack & ~i_mem_ack;
    o_m1_err      = o_m1_ack & ~i_mem_ack;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a round-robin instance and a fixed-priority
// instance share all inputs; each vector selects which one is compared.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_addr, m0_wd, m1_addr, m1_wd, mem_rd;
  logic [1:0]  m0_size, m1_size;
  logic        m0_we, m0_req, m1_we, m1_req, mem_ack;

  logic [31:0] r_m0_rd, r_m1_rd, r_mem_addr, r_mem_wd;
  logic [1:0]  r_mem_size;
  logic        r_m0_ack, r_m0_err, r_m1_ack, r_m1_err, r_mem_we, r_mem_req;
  logic [31:0] f_m0_rd, f_m1_rd, f_mem_addr, f_mem_wd;
  logic [1:0]  f_mem_size;
  logic        f_m0_ack, f_m0_err, f_m1_ack, f_m1_err, f_mem_we, f_mem_req;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(1'b1), .TIMEOUT(15),
                     .ERR_DATA(32'hDEAD_BEEF)) u_rr (
    .i_clk(clk), .i_rst(rst),
    .i_m0_addr(m0_addr), .i_m0_wr_data(m0_wd), .i_m0_size(m0_size), .i_m0_we(m0_we),
    .i_m0_req(m0_req), .o_m0_rd_data(r_m0_rd), .o_m0_ack(r_m0_ack), .o_m0_err(r_m0_err),
    .i_m1_addr(m1_addr), .i_m1_wr_data(m1_wd), .i_m1_size(m1_size), .i_m1_we(m1_we),
    .i_m1_req(m1_req), .o_m1_rd_data(r_m1_rd), .o_m1_ack(r_m1_ack), .o_m1_err(r_m1_err),
    .o_mem_addr(r_mem_addr), .o_mem_wr_data(r_mem_wd), .o_mem_size(r_mem_size),
    .o_mem_we(r_mem_we), .o_mem_req(r_mem_req), .i_mem_rd_data(mem_rd), .i_mem_ack(mem_ack)
  );

  mem_port_arbiter #(.ADDR_WIDTH(32), .ROUND_ROBIN(1'b0), .TIMEOUT(15),
                     .ERR_DATA(32'hDEAD_BEEF)) u_fp (
    .i_clk(clk), .i_rst(rst),
    .i_m0_addr(m0_addr), .i_m0_wr_data(m0_wd), .i_m0_size(m0_size), .i_m0_we(m0_we),
    .i_m0_req(m0_req), .o_m0_rd_data(f_m0_rd), .o_m0_ack(f_m0_ack), .o_m0_err(f_m0_err),
    .i_m1_addr(m1_addr), .i_m1_wr_data(m1_wd), .i_m1_size(m1_size), .i_m1_we(m1_we),
    .i_m1_req(m1_req), .o_m1_rd_data(f_m1_rd), .o_m1_ack(f_m1_ack), .o_m1_err(f_m1_err),
    .o_mem_addr(f_mem_addr), .o_mem_wr_data(f_mem_wd), .o_mem_size(f_mem_size),
    .o_mem_we(f_mem_we), .o_mem_req(f_mem_req), .i_mem_rd_data(mem_rd), .i_mem_ack(mem_ack)
  );

  typedef struct packed {
    logic        fp;  // compare the fixed-priority instance instead of round-robin
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        mack;
    logic [31:0] mrd;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wd;
    logic [1:0]  e_size;
    logic        e_a0, e_e0, e_a1, e_e1;
    logic [31:0] e_rd;
  } vec_t;

  vec_t  tbl[$];
  vec_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    vidx    = 0;
  string tag     = "";

  function automatic vec_t vin(input logic rs, input logic r0, input logic w0,
                               input logic [31:0] a0, input logic [31:0] d0,
                               input logic r1, input logic w1,
                               input logic [31:0] a1, input logic [31:0] d1,
                               input logic mack, input logic [31:0] mrd);
    vec_t v;
    v = '0;
    v.rst = rs; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.mack = mack; v.mrd = mrd;
    return v;
  endfunction

  // Expect a grant to requester m (M0 size is 2, M1 size is 0 in this bench).
  function automatic vec_t eg(input vec_t v, input logic m, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
    v.e_req = 1'b1; v.e_we = we; v.e_addr = a; v.e_wd = d;
    v.e_size = m ? 2'd0 : 2'd2;
    return v;
  endfunction

  function automatic vec_t ea(input vec_t v, input logic m, input logic err,
                              input logic [31:0] rd);
    if (m) begin v.e_a1 = 1'b1; v.e_e1 = err; end
    else begin v.e_a0 = 1'b1; v.e_e0 = err; end
    v.e_rd = rd;
    return v;
  endfunction

  function automatic vec_t fpv(input vec_t v);
    v.fp = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s#%0d: got %h expected %h", tag, name, vidx, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
  task automatic apply(input vec_t v);
    vec_t e;
    rst = v.rst;
    m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wd = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wd = v.d1;
    mem_ack = v.mack; mem_rd = v.mrd;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    if (e.fp) begin
      check("mem_req", 32'(f_mem_req), 32'(e.e_req));
      check("mem_we", 32'(f_mem_we), 32'(e.e_we));
      if (e.e_req) begin
        check("mem_addr", f_mem_addr, e.e_addr);
        check("mem_size", 32'(f_mem_size), 32'(e.e_size));
      end
      check("m0_ack", 32'(f_m0_ack), 32'(e.e_a0));
      check("m0_err", 32'(f_m0_err), 32'(e.e_e0));
      check("m1_ack", 32'(f_m1_ack), 32'(e.e_a1));
      check("m1_err", 32'(f_m1_err), 32'(e.e_e1));
      if (e.e_a0) check("m0_rd", f_m0_rd, e.e_rd);
      if (e.e_a1) check("m1_rd", f_m1_rd, e.e_rd);
    end else begin
      check("mem_req", 32'(r_mem_req), 32'(e.e_req));
      check("mem_we", 32'(r_mem_we), 32'(e.e_we));
      if (e.e_req) begin
        check("mem_addr", r_mem_addr, e.e_addr);
        check("mem_wd", r_mem_wd, e.e_wd);
        check("mem_size", 32'(r_mem_size), 32'(e.e_size));
      end
      check("m0_ack", 32'(r_m0_ack), 32'(e.e_a0));
      check("m0_err", 32'(r_m0_err), 32'(e.e_e0));
      check("m1_ack", 32'(r_m1_ack), 32'(e.e_a1));
      check("m1_err", 32'(r_m1_err), 32'(e.e_e1));
      if (e.e_a0) check("m0_rd", r_m0_rd, e.e_rd);
      if (e.e_a1) check("m1_rd", r_m1_rd, e.e_rd);
    end
    vidx++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    apply(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t b, ba, v;
    rst = 1'b1; m0_size = 2'd2; m1_size = 2'd0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
    mem_ack = 0; mem_rd = 0;
    @(posedge clk);
    #1;

    // Reset, then round-robin between two held writers: M0 first after reset.
    tbl.push_back(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(vin(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1));
    b  = vin(0, 1, 1, 32'h20, 32'hAAAA_0000, 1, 1, 32'h24, 32'h5555_0000, 0, 0);
    ba = vin(0, 1, 1, 32'h20, 32'hAAAA_0000, 1, 1, 32'h24, 32'h5555_0000, 1, 0);
    for (int i = 0; i < 2; i++) begin
      tbl.push_back(eg(b, 0, 1, 32'h20, 32'hAAAA_0000));
      tbl.push_back(ea(ba, 0, 0, 32'h0));
      tbl.push_back(eg(b, 1, 1, 32'h24, 32'h5555_0000));
      tbl.push_back(ea(ba, 1, 0, 32'h0));
    end
    tbl.push_back(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Single M0 read with a one-cycle memory.
    tbl.push_back(eg(vin(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h10, 32'h0));
    tbl.push_back(ea(vin(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 32'h1234_5678), 0, 0,
                     32'h1234_5678));
    tbl.push_back(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Stray memory ack while idle produces nothing.
    tbl.push_back(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hFFFF_0000));
    // Single M1 read.
    tbl.push_back(eg(vin(0, 0, 0, 0, 0, 1, 0, 32'h30, 0, 0, 0), 1, 0, 32'h30, 32'h0));
    tbl.push_back(ea(vin(0, 0, 0, 0, 0, 1, 0, 32'h30, 0, 1, 32'hCAFE_F00D), 1, 0,
                     32'hCAFE_F00D));
    // M0 drops req while waiting; transaction still completes.
    tbl.push_back(eg(vin(0, 1, 0, 32'h14, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h14, 32'h0));
    tbl.push_back(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(ea(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_2222), 0, 0,
                     32'h1111_2222));
    tbl.push_back(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tag = "table";
    foreach (tbl[i]) apply(tbl[i]);

    // Timeout on an M1 read, then a late ack that must be ignored.
    tag = "timeout"; vidx = 0;
    apply(eg(vin(0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0), 1, 0, 32'h40, 32'h0));
    for (int k = 1; k < 15; k++) apply(vin(0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0));
    apply(ea(vin(0, 0, 0, 0, 0, 1, 0, 32'h40, 0, 0, 0), 1, 1, 32'hDEAD_BEEF));
    apply(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777_7777));
    apply(eg(vin(0, 1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h44, 32'h0));
    apply(ea(vin(0, 1, 0, 32'h44, 0, 0, 0, 0, 0, 1, 32'h4444_0000), 0, 0, 32'h4444_0000));
    apply(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Ack arriving exactly in the timeout cycle wins.
    tag = "collide"; vidx = 0;
    apply(eg(vin(0, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h48, 32'h0));
    for (int k = 1; k < 15; k++) apply(vin(0, 1, 0, 32'h48, 0, 0, 0, 0, 0, 0, 0));
    apply(ea(vin(0, 1, 0, 32'h48, 0, 0, 0, 0, 0, 1, 32'h0BAD_F00D), 0, 0, 32'h0BAD_F00D));
    apply(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset while waiting: no ack for the dropped transaction, M0 wins the next tie.
    tag = "rst_mid"; vidx = 0;
    apply(eg(vin(0, 1, 0, 32'h18, 0, 0, 0, 0, 0, 0, 0), 0, 0, 32'h18, 32'h0));
    apply(vin(1, 1, 0, 32'h18, 0, 0, 0, 0, 0, 0, 0));
    v = vin(0, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 1, 32'h9999_9999);
    apply(eg(v, 0, 0, 32'h18, 32'h0));
    apply(ea(vin(0, 1, 0, 32'h18, 0, 1, 0, 32'h1C, 0, 1, 32'h1818_1818), 0, 0,
             32'h1818_1818));
    apply(eg(vin(0, 0, 0, 0, 0, 1, 0, 32'h1C, 0, 0, 0), 1, 0, 32'h1C, 32'h0));
    apply(ea(vin(0, 0, 0, 0, 0, 1, 0, 32'h1C, 0, 1, 32'h1C1C_1C1C), 1, 0, 32'h1C1C_1C1C));
    apply(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Fixed priority: M0 wins every tie; M1 only once M0 lets go.
    tag = "fixed"; vidx = 0;
    do_reset();
    b  = vin(0, 1, 0, 32'h50, 0, 1, 0, 32'h54, 0, 0, 0);
    ba = vin(0, 1, 0, 32'h50, 0, 1, 0, 32'h54, 0, 1, 32'h5050_5050);
    for (int i = 0; i < 3; i++) begin
      apply(fpv(eg(b, 0, 0, 32'h50, 32'h0)));
      apply(fpv(ea(ba, 0, 0, 32'h5050_5050)));
    end
    apply(fpv(eg(vin(0, 0, 0, 0, 0, 1, 0, 32'h54, 0, 0, 0), 1, 0, 32'h54, 32'h0)));
    apply(fpv(ea(vin(0, 0, 0, 0, 0, 1, 0, 32'h54, 0, 1, 32'h5454_5454), 1, 0,
                 32'h5454_5454)));
    apply(fpv(vin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
